// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port SRAM between instruction fetch (IF) and the MEM
//   stage. Each access is sequenced over a variable-latency req/ack SRAM
//   handshake, and freeze outputs hold the pipeline registers until the
//   requesting stage's access has completed.
//
// Parameters
//   ADDR_W      address width, all ports
//   DATA_W      data width, all ports
//   TIMEOUT     max cycles in a grant state without sram_ack before ERROR
//   STARVE_MAX  consecutive MEM grants (while if_req pending) before IF wins
//
// Ports
//   clk, rst                      rising-edge clock, async active-low reset
//   if_req/if_addr                fetch request (level) and PC
//   if_rdata/if_valid             fetched word and one-cycle completion pulse
//   mem_r_en/mem_w_en             MEM-stage load / store request (levels)
//   mem_addr/mem_wdata            load/store address and store data
//   mem_rdata/mem_done            load data and one-cycle completion pulse
//   freeze_if                     hold PC and IF/ID register
//   freeze_pipe                   hold ID/EXE, EXE/MEM and MEM/WB registers
//   sram_req/we/addr/wdata        SRAM request side, stable during an access
//   sram_rdata/sram_ack           SRAM response, sampled at the clk edge
//   err_timeout                   sticky fatal error, cleared only by rst
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              freeze_if,
  output logic              freeze_pipe,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,
  output logic              err_timeout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int ST_W = $clog2(STARVE_MAX + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GRANT_IF  = 2'd1,
    S_GRANT_MEM = 2'd2,
    S_ERROR     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [ST_W-1:0]   streak_q, streak_d;
  logic              if_flush_q, if_flush_d;
  logic              sram_req_q, sram_req_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_done_q, mem_done_d;
  logic              err_q, err_d;

  logic mem_elig;
  logic if_elig;
  logic if_wins;
  logic flushed;

  always_comb begin
    // NOTE: every _d starts from its hold value, so no branch of the case
    // below can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    streak_d     = streak_q;
    if_flush_d   = if_flush_q;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_valid_d   = 1'b0;
    mem_done_d   = 1'b0;
    err_d        = err_q;

    // A requester whose done pulse is high right now is not eligible, so the
    // other side always gets a chance in the gap cycle.
    mem_elig = (mem_r_en | mem_w_en) & ~mem_done_q;
    if_elig  = if_req & ~if_valid_q;
    if_wins  = if_elig & (streak_q == ST_MAX);
    // A fetch that lost its request at any point during the grant is stale.
    flushed  = if_flush_q | ~if_req;

    case (state_q)
      S_IDLE: begin
        if (mem_elig && !if_wins) begin
          state_d      = S_GRANT_MEM;
          tcnt_d       = '0;
          sram_req_d   = 1'b1;
          sram_we_d    = mem_w_en;  // a store wins when both enables are set
          sram_addr_d  = mem_addr;
          sram_wdata_d = mem_w_en ? mem_wdata : '0;
          if (!if_req)               streak_d = '0;
          else if (streak_q != ST_MAX) streak_d = streak_q + ST_W'(1);
        end else if (if_elig) begin
          state_d      = S_GRANT_IF;
          tcnt_d       = '0;
          sram_req_d   = 1'b1;
          sram_we_d    = 1'b0;
          sram_addr_d  = if_addr;
          sram_wdata_d = '0;
          streak_d     = '0;
          if_flush_d   = 1'b0;
        end
      end

      S_GRANT_IF, S_GRANT_MEM: begin
        if (state_q == S_GRANT_IF && !if_req) if_flush_d = 1'b1;
        if (sram_ack) begin
          state_d    = S_IDLE;
          tcnt_d     = '0;
          sram_req_d = 1'b0;
          if (state_q == S_GRANT_IF) begin
            if (!flushed) begin
              if_valid_d = 1'b1;
              if_rdata_d = sram_rdata;
            end
          end else begin
            mem_done_d = 1'b1;
            if (!sram_we_q) mem_rdata_d = sram_rdata;
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d    = S_ERROR;
          tcnt_d     = '0;
          sram_req_d = 1'b0;
          err_d      = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end

      S_ERROR: begin
        sram_req_d = 1'b0;
        err_d      = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: there is no storage array here; every register, including the
    // captured read data and the SRAM address/data, is cleared by reset.
    if (!rst) begin
      state_q      <= S_IDLE;
      tcnt_q       <= '0;
      streak_q     <= '0;
      if_flush_q   <= 1'b0;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_valid_q   <= 1'b0;
      mem_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, independent of statement order.
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      streak_q     <= streak_d;
      if_flush_q   <= if_flush_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_valid_q   <= if_valid_d;
      mem_done_q   <= mem_done_d;
      err_q        <= err_d;
    end
  end

  assign sram_req    = sram_req_q;
  assign sram_we     = sram_we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_wdata  = sram_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign if_valid    = if_valid_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_done    = mem_done_q;
  assign err_timeout = err_q;

  // The freezes are combinational so the pipeline stalls in the same cycle a
  // request appears; rst forces them low so every output is 0 in reset.
  assign freeze_pipe = rst & (((mem_r_en | mem_w_en) & ~mem_done_q) | (state_q == S_ERROR));
  assign freeze_if   = freeze_pipe | (rst & if_req & ~if_valid_q);

endmodule
